pipe_stage_skid: RTL
====================

// Module: pipe_stage_skid
// PURPOSE
//  Generic elastic pipeline-stage register for the ARM pipeline; first user is the MEM->WB boundary.
//  Carries a data payload plus control bits between stages with a valid/ready handshake.
//  A 2-entry skid buffer keeps in_ready registered; flush inserts a bubble.
//  Control bits are forced to 0 whenever the output is not valid, so no RegWrite is issued on a bubble.
//  Saturating stall/bubble counters support performance debug.
// PARAMETERS
//  DATA_W  68  payload width (default = ReadData 32 + ALUOut 32 + WA3 4)
//  CTRL_W  2   control-bit width (default = {MemToReg, RegWrite})
//  STAT_W  16  width of each statistics counter
// PORTS
//  clk         in   1       sole clock; all state updates on posedge
//  reset       in   1       synchronous, active-high
//  flush       in   1       discard all held entries; synchronous
//  in_valid    in   1       upstream has a beat
//  in_ready    out  1       stage can accept; registered (function of state only)
//  in_data     in   DATA_W  upstream payload
//  in_ctrl     in   CTRL_W  upstream control bits
//  out_valid   out  1       downstream beat present
//  out_ready   in   1       downstream accepts
//  out_data    out  DATA_W  payload of head entry
//  out_ctrl    out  CTRL_W  head control bits AND {CTRL_W{out_valid}}
//  occupancy   out  2       held entries: 0, 1 or 2
//  stat_clr    in   1       synchronous clear of both counters
//  stall_cnt   out  STAT_W  cycles with out_valid & !out_ready; saturating
//  bubble_cnt  out  STAT_W  cycles with out_ready & !out_valid; saturating
// BEHAVIOUR
//  - Reset: state EMPTY; main/skid regs 0; in_ready=1; out_valid=0; out_data=0; out_ctrl=0; occupancy=0; counters 0.
//  - Transfer rules: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
//  - States and transitions:
//    - EMPTY
//      - in_xfer -> BUSY; main<=in.
//    - BUSY (main valid)
//      - in_xfer & out_xfer -> BUSY; main<=in.
//      - in_xfer & !out_ready -> FULL; skid<=in.
//      - !in_valid & out_xfer -> EMPTY.
//      - otherwise hold.
//    - FULL (main+skid valid; in_ready=0)
//      - out_ready -> BUSY; main<=skid.
//      - otherwise hold.
//  - Outputs: in_ready = (state!=FULL); out_valid = (state!=EMPTY); out_data = main.
//  - Latency: 1 cycle, in_xfer to out_valid. Throughput: 1 beat/cycle while out_ready=1.
//  - Ordering: strict FIFO; skid data is never overtaken by in_data.
//  - flush (priority below reset, above everything else):
//    - next state EMPTY.
//    - An in_xfer in the same cycle is discarded.
//    - An out_xfer in the same cycle is complete; downstream keeps it.
//    - Data regs need not clear, but out_ctrl is 0 from the next cycle.
//  - Counters:
//    - Increment per definition above, saturating at all-ones (no wrap).
//    - stat_clr forces 0 and beats a same-cycle increment. Counters are unaffected by flush.
//  - Reset mid-transfer: held beats are lost; in_ready=1 the following cycle.
// STRUCTURE
//  - pipe_pkg holds:
//    - typedef enum logic [1:0] {EMPTY, BUSY, FULL} skid_state_t
//    - MEMWB_DATA_W=68, MEMWB_CTRL_W=2
//    - MEMWB field offsets: RD [67:36], ALUOut [35:4], WA3 [3:0]
//  - Sub-module sat_counter #(W): inc, clr -> cnt. Instantiated twice (stall, bubble).
// TESTING
//  1. Reset with in_valid=1 -> in_ready=1, out_valid=0, out_ctrl=0, counters 0 the cycle after reset drops.
//  2. out_ready=1; stream 0x11,0x22,0x33 (ctrl=2'b01) -> each appears 1 cycle later; no stall; occupancy<=1.
//  3. out_ready=0; send 0xA,0xB -> occupancy=2, in_ready=0; third beat 0xC held off.
//     Then out_ready=1 -> 0xA,0xB,0xC in order; stall_cnt=2.
//  4. FULL with ctrl=2'b11; flush=1 while in_valid=1 -> next cycle out_valid=0, out_ctrl=0, occupancy=0;
//     the flushed input is never output.
//  5. STAT_W=4; hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt sticks at 15;
//     stat_clr with a same-cycle increment -> 0.
//  6. Random valid/ready (10k cycles) vs scoreboard -> zero loss/dup/reorder; out_ctrl==0 whenever out_valid==0.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types and MEM->WB payload layout for elastic pipeline-stage registers.
package pipe_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } skid_state_t;

   localparam int unsigned MEMWB_DATA_W = 68;
   localparam int unsigned MEMWB_CTRL_W = 2;

   localparam int unsigned MEMWB_RD_MSB     = 67;
   localparam int unsigned MEMWB_RD_LSB     = 36;
   localparam int unsigned MEMWB_ALUOUT_MSB = 35;
   localparam int unsigned MEMWB_ALUOUT_LSB = 4;
   localparam int unsigned MEMWB_WA3_MSB    = 3;
   localparam int unsigned MEMWB_WA3_LSB    = 0;

   typedef struct packed {
      logic [31:0] rd;
      logic [31:0] alu_out;
      logic [3:0]  wa3;
   } memwb_data_t;

   // Number of beats held in each state.
   function automatic logic [1:0] occ_of(skid_state_t s);
      case (s)
         EMPTY:   occ_of = 2'd0;
         BUSY:    occ_of = 2'd1;
         default: occ_of = 2'd2;
      endcase
   endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer so in_ready depends on state only.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = MEMWB_DATA_W,
   parameter int unsigned CTRL_W = MEMWB_CTRL_W,
   parameter int unsigned STAT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   input  logic              stat_clr,
   output logic [STAT_W-1:0] stall_cnt,
   output logic [STAT_W-1:0] bubble_cnt
);

   localparam int unsigned ENT_W = DATA_W + CTRL_W;

   skid_state_t      state_q, state_d;
   logic [ENT_W-1:0] main_q, main_d;
   logic [ENT_W-1:0] skid_q, skid_d;
   logic [ENT_W-1:0] in_ent;
   logic             in_xfer;
   logic             out_xfer;

   assign in_ent   = {in_ctrl, in_data};
   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         EMPTY: begin
            if (in_xfer) begin
               state_d = BUSY;
               main_d  = in_ent;
            end
         end
         BUSY: begin
            if (in_xfer && out_xfer) begin
               main_d = in_ent;
            end else if (in_xfer && !out_ready) begin
               state_d = FULL;
               skid_d  = in_ent;
            end else if (!in_valid && out_xfer) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            // Skid drains into main before any new beat is accepted, preserving order.
            if (out_ready) begin
               state_d = BUSY;
               main_d  = skid_q;
            end
         end
         default: state_d = EMPTY;
      endcase
      if (flush) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q[DATA_W-1:0];
   // Control bits are gated so a bubble never carries RegWrite downstream.
   assign out_ctrl  = main_q[ENT_W-1:DATA_W] & {CTRL_W{out_valid}};
   assign occupancy = occ_of(state_q);

   sat_counter #(.W(STAT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_valid & ~out_ready),
      .clr   (stat_clr),
      .cnt   (stall_cnt)
   );

   sat_counter #(.W(STAT_W)) u_bubble_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (out_ready & ~out_valid),
      .clr   (stat_clr),
      .cnt   (bubble_cnt)
   );

endmodule
